alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Drives the 32-bit ALU (ALUop AND=000 OR=001 ADD=010 SUB=110 SLT=111) from the instruction side.
//  Accepts one MIPS-style command (opcode, funct, two operands) per valid/ready handshake.
//  Decodes it to an ALUop, presents operands to the ALU for one cycle, then captures Result/Zero/CarryOut/Overflow.
//  Returns them, plus decode status, on a response valid/ready channel; sits between decode stage and ALU.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must match the attached ALU
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  rst          in   1           synchronous, active-high reset
//  cmd_valid    in   1           command present
//  cmd_ready    out  1           block can accept a command (high only in IDLE)
//  cmd_opcode   in   6           instr[31:26]
//  cmd_funct    in   6           instr[5:0], used only when opcode==0
//  cmd_a        in   DATA_WIDTH  operand A
//  cmd_b        in   DATA_WIDTH  operand B (already sign/zero-extended imm for I-type)
//  alu_A        out  DATA_WIDTH  to ALU A (registered)
//  alu_B        out  DATA_WIDTH  to ALU B (registered)
//  alu_op       out  3           to ALU ALUop (registered)
//  alu_Result   in   DATA_WIDTH  from ALU
//  alu_Zero     in   1           from ALU
//  alu_CarryOut in   1           from ALU
//  alu_Overflow in   1           from ALU
//  rsp_valid    out  1           response present
//  rsp_ready    in   1           consumer accepts response
//  rsp_result   out  DATA_WIDTH  captured Result (0 if illegal)
//  rsp_zero     out  1           captured Zero
//  rsp_carry    out  1           captured CarryOut
//  rsp_ovf_trap out  1           Overflow AND op is trapping (add, addi, sub)
//  rsp_illegal  out  1           opcode/funct not decodable
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1 after reset; rsp_* all 0; alu_A/alu_B=0, alu_op=3'b000.
//  - rst mid-operation aborts: any pending command/response discarded, next cycle as above.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//    IDLE: cmd_ready=1; on cmd_valid register operands, decoded alu_op, trap/illegal flags.
//          Legal -> EXEC; illegal -> RESP directly (result/zero/carry/trap = 0, rsp_illegal=1).
//    EXEC: one cycle, alu_* stable; at cycle end capture ALU outputs into rsp_*; -> RESP.
//    RESP: rsp_valid=1, rsp_* held stable; on rsp_ready -> IDLE (rsp_valid low next cycle).
//  - Latency legal: handshake edge N, rsp_valid high from N+2. Illegal: from N+1.
//  - Throughput: max 1 command / 3 cycles; cmd_ready never high while rsp_valid high.
//  - rsp_ready high before rsp_valid is ignored; rsp_valid never drops without rsp_ready.
//  - Decode, opcode==0 by funct: 100000 add, 100010 sub (trapping); 100001 addu, 100011 subu;
//    100100 and; 100101 or; 101010 slt. Other funct -> illegal.
//  - Decode I-type: 001000 addi (trap), 001001 addiu, 100011 lw, 101011 sw -> ADD;
//    001100 andi -> AND; 001101 ori -> OR; 001010 slti -> SLT;
//    000100 beq, 000101 bne -> SUB (non-trap). Other opcodes -> illegal.
//  - rsp_ovf_trap = captured alu_Overflow & trap flag; non-trapping ops report 0 even if ALU overflows.
//  - alu_* outputs retain last values outside EXEC (no glitch-to-zero required).
// STRUCTURE
//  - Shared header alu_defs.vh: DATA_WIDTH, ALUop codes AND/OR/ADD/SUB/SLT, opcode/funct constants.
//  - One combinational sub-module alu_op_decode: (opcode, funct) -> (alu_op, trap, illegal).
//  - Top holds FSM, operand/response registers; ALU instantiated outside this block.
// TESTING (bench instantiates real alu alongside)
//  - add 0x7FFFFFFF+0x00000001 -> rsp_result 0x80000000, rsp_ovf_trap=1; same via addu -> trap=0.
//  - sub 5-5 (funct 100010) -> result 0, rsp_zero=1, rsp_valid at N+2, illegal=0.
//  - slti A=0xFFFFFFFF B=0x00000001 -> alu_op=111, result 0x00000001.
//  - opcode 0x3F -> rsp_illegal=1, result 0, rsp_valid at N+1, alu_op unchanged.
//  - hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, new cmd_valid not accepted.
//  - assert rst during EXEC -> next cycle rsp_valid=0, cmd_ready=1, alu_op=000, no response emitted.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU operation codes,
// MIPS opcode/funct constants, FSM states and the decode result record.
package alu_issue_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // ALUop encoding understood by the attached ALU
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    alu_op_e op;
    logic    trap;
    logic    illegal;
  } decode_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, response and ALU-side signal bundle of the ALU issue controller.
// The slave modport is the controller's view; master is its environment.
interface alu_issue_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [5:0]            cmd_opcode;
  logic [5:0]            cmd_funct;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;

  logic [DATA_WIDTH-1:0] alu_A;
  logic [DATA_WIDTH-1:0] alu_B;
  logic [2:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_Result;
  logic                  alu_Zero;
  logic                  alu_CarryOut;
  logic                  alu_Overflow;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;
  logic                  rsp_carry;
  logic                  rsp_ovf_trap;
  logic                  rsp_illegal;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_funct, cmd_a, cmd_b,
    output cmd_ready,
    output alu_A, alu_B, alu_op,
    input  alu_Result, alu_Zero, alu_CarryOut, alu_Overflow,
    output rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf_trap, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_funct, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_A, alu_B, alu_op,
    output alu_Result, alu_Zero, alu_CarryOut, alu_Overflow,
    input  rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf_trap, rsp_illegal,
    output rsp_ready
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational MIPS (opcode, funct) -> ALUop decoder. Also flags the
// overflow-trapping arithmetic forms and anything not decodable.
module alu_issue_ctrl_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec
);

  // Map opcode (and funct for R-type) to operation, trap and illegal flags
  always_comb begin
    dec.op      = ALU_AND;
    dec.trap    = 1'b0;
    dec.illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin dec.op = ALU_ADD; dec.trap = 1'b1; end
          FN_SUB:  begin dec.op = ALU_SUB; dec.trap = 1'b1; end
          FN_ADDU: dec.op = ALU_ADD;
          FN_SUBU: dec.op = ALU_SUB;
          FN_AND:  dec.op = ALU_AND;
          FN_OR:   dec.op = ALU_OR;
          FN_SLT:  dec.op = ALU_SLT;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin dec.op = ALU_ADD; dec.trap = 1'b1; end
      OP_ADDIU: dec.op = ALU_ADD;
      OP_LW:    dec.op = ALU_ADD;
      OP_SW:    dec.op = ALU_ADD;
      OP_ANDI:  dec.op = ALU_AND;
      OP_ORI:   dec.op = ALU_OR;
      OP_SLTI:  dec.op = ALU_SLT;
      OP_BEQ:   dec.op = ALU_SUB;
      OP_BNE:   dec.op = ALU_SUB;
      default:  dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one command per handshake, drives the
// external ALU for one cycle, captures its flags and returns a response.
// Illegal commands skip the ALU cycle and leave the ALU inputs untouched.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);

  state_e                state_r;
  state_e                state_s;
  decode_t               dec_s;

  logic [DATA_WIDTH-1:0] alu_a_r;
  logic [DATA_WIDTH-1:0] alu_b_r;
  logic [2:0]            alu_op_r;
  logic                  trap_r;

  logic                  cmd_ready_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_result_r;
  logic                  rsp_zero_r;
  logic                  rsp_carry_r;
  logic                  rsp_ovf_trap_r;
  logic                  rsp_illegal_r;

  alu_issue_ctrl_decode u_decode (
    .opcode (bus.cmd_opcode),
    .funct  (bus.cmd_funct),
    .dec    (dec_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: illegal commands go straight to the response phase
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_s = dec_s.illegal ? ST_RESP : ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      cmd_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
    end
  end

  // Operand launch on accept, ALU result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_r        <= '0;
      alu_b_r        <= '0;
      alu_op_r       <= 3'b000;
      trap_r         <= 1'b0;
      rsp_result_r   <= '0;
      rsp_zero_r     <= 1'b0;
      rsp_carry_r    <= 1'b0;
      rsp_ovf_trap_r <= 1'b0;
      rsp_illegal_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (dec_s.illegal) begin
              rsp_result_r   <= '0;
              rsp_zero_r     <= 1'b0;
              rsp_carry_r    <= 1'b0;
              rsp_ovf_trap_r <= 1'b0;
              rsp_illegal_r  <= 1'b1;
            end else begin
              alu_a_r  <= bus.cmd_a;
              alu_b_r  <= bus.cmd_b;
              alu_op_r <= dec_s.op;
              trap_r   <= dec_s.trap;
            end
          end
        end
        ST_EXEC: begin
          rsp_result_r   <= bus.alu_Result;
          rsp_zero_r     <= bus.alu_Zero;
          rsp_carry_r    <= bus.alu_CarryOut;
          rsp_ovf_trap_r <= bus.alu_Overflow & trap_r;
          rsp_illegal_r  <= 1'b0;
        end
        default: begin
          rsp_result_r   <= rsp_result_r;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_r;
  assign bus.alu_A        = alu_a_r;
  assign bus.alu_B        = alu_b_r;
  assign bus.alu_op       = alu_op_r;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_result   = rsp_result_r;
  assign bus.rsp_zero     = rsp_zero_r;
  assign bus.rsp_carry    = rsp_carry_r;
  assign bus.rsp_ovf_trap = rsp_ovf_trap_r;
  assign bus.rsp_illegal  = rsp_illegal_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a behavioural 32-bit ALU answers the
// controller, directed vectors come from a table, random commands are
// checked against a reference model working from the MIPS semantics.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        t;
    logic        il;
    logic [2:0]  aluop;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [2:0] last_alu_op;

  alu_issue_ctrl_if #(.DATA_WIDTH(32)) bus ();

  alu_issue_ctrl #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU attached to the controller
  always_comb begin
    logic [32:0] s33;
    logic [31:0] r;
    logic        sub_ovf;
    s33 = {1'b0, bus.alu_A} + {1'b0, ~bus.alu_B} + 33'd1;
    r = s33[31:0];
    sub_ovf = (bus.alu_A[31] & ~bus.alu_B[31] & ~r[31]) | (~bus.alu_A[31] & bus.alu_B[31] & r[31]);
    bus.alu_Result   = 32'd0;
    bus.alu_CarryOut = 1'b0;
    bus.alu_Overflow = 1'b0;
    case (bus.alu_op)
      3'b000: bus.alu_Result = bus.alu_A & bus.alu_B;
      3'b001: bus.alu_Result = bus.alu_A | bus.alu_B;
      3'b010: begin
        s33 = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
        bus.alu_Result   = s33[31:0];
        bus.alu_CarryOut = s33[32];
        bus.alu_Overflow = (bus.alu_A[31] & bus.alu_B[31] & ~s33[31]) | (~bus.alu_A[31] & ~bus.alu_B[31] & s33[31]);
      end
      3'b110: begin
        bus.alu_Result   = r;
        bus.alu_CarryOut = s33[32];
        bus.alu_Overflow = sub_ovf;
      end
      3'b111: begin
        bus.alu_Result   = {31'd0, r[31] ^ sub_ovf};
        bus.alu_CarryOut = s33[32];
        bus.alu_Overflow = sub_ovf;
      end
      default: bus.alu_Result = 32'd0;
    endcase
    bus.alu_Zero = (bus.alu_Result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the instruction semantics
  function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    int     kind;   // 0 and, 1 or, 2 add, 3 sub, 4 slt, -1 illegal
    bit     trapping;
    longint s;
    bit     ovf;
    kind = -1;
    trapping = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: begin kind = 2; trapping = 1'b1; end
        6'h22: begin kind = 3; trapping = 1'b1; end
        6'h21: kind = 2;
        6'h23: kind = 3;
        6'h24: kind = 0;
        6'h25: kind = 1;
        6'h2A: kind = 4;
        default: kind = -1;
      endcase
      6'h08: begin kind = 2; trapping = 1'b1; end
      6'h09, 6'h23, 6'h2B: kind = 2;
      6'h0C: kind = 0;
      6'h0D: kind = 1;
      6'h0A: kind = 4;
      6'h04, 6'h05: kind = 3;
      default: kind = -1;
    endcase
    e.res = 32'd0; e.z = 1'b0; e.c = 1'b0; e.t = 1'b0; e.il = 1'b0; e.aluop = 3'b000;
    ovf = 1'b0;
    case (kind)
      0: begin e.res = a & b; e.aluop = 3'b000; end
      1: begin e.res = a | b; e.aluop = 3'b001; end
      2: begin
        e.res = a + b;
        e.c = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
        s = longint'($signed(a)) + longint'($signed(b));
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.aluop = 3'b010;
      end
      3: begin
        e.res = a - b;
        e.c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.aluop = 3'b110;
      end
      4: begin
        e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        e.c = (a >= b);
        e.aluop = 3'b111;
      end
      default: e.il = 1'b1;
    endcase
    e.z = (kind >= 0) && (e.res == 32'd0);
    e.t = trapping && ovf;
    return e;
  endfunction

  // Issue one command, check latency, response, optional backpressure and release
  task automatic run_cmd(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e, input int hold, input bit poke);
    int lat;
    logic [2:0] exp_op;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_funct = fn;
    bus.cmd_a = a; bus.cmd_b = b;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = 6'($urandom); bus.cmd_funct = 6'($urandom);
    bus.cmd_a = $urandom; bus.cmd_b = $urandom;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), e.il ? 32'd1 : 32'd2);
    exp_op = e.il ? last_alu_op : e.aluop;
    last_alu_op = exp_op;
    chk("alu_op", 32'(bus.alu_op), 32'(exp_op));
    chk("rsp_result", bus.rsp_result, e.res);
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.z));
    chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
    chk("rsp_ovf_trap", 32'(bus.rsp_ovf_trap), 32'(e.t));
    chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.il));
    chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 6'h00; bus.cmd_funct = 6'h25;
        bus.cmd_a = 32'h1234_5678; bus.cmd_b = 32'h0F0F_0000;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_result", bus.rsp_result, e.res);
      chk("hold_flags", {28'd0, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf_trap, bus.rsp_illegal},
          {28'd0, e.z, e.c, e.t, e.il});
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("release_ready", 32'(bus.cmd_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[14];
  logic [5:0] legal_ops[10] = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0A, 6'h04, 6'h05};
  logic [5:0] legal_fns[7]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic z,
                              input logic c, input logic t, input logic il, input logic [2:0] aluop);
    vec_t v;
    v.op = op; v.fn = fn; v.a = a; v.b = b;
    v.e.res = res; v.e.z = z; v.e.c = c; v.e.t = t; v.e.il = il; v.e.aluop = aluop;
    return v;
  endfunction

  initial begin
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [31:0] a;
    logic [31:0] b;
    n_vec = 0; n_err = 0; last_alu_op = 3'b000;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = 6'd0; bus.cmd_funct = 6'd0;
    bus.cmd_a = 32'd0; bus.cmd_b = 32'd0; bus.rsp_ready = 1'b0;

    //            op     fn     a             b             result        z     c     t     il    aluop
    tbl[0]  = mk(6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
    tbl[1]  = mk(6'h00, 6'h21, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    tbl[2]  = mk(6'h00, 6'h22, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110);
    tbl[3]  = mk(6'h0A, 6'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111);
    tbl[4]  = mk(6'h3F, 6'h00, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111);
    tbl[5]  = mk(6'h00, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    tbl[6]  = mk(6'h0D, 6'h11, 32'h00001234, 32'hFFFF0000, 32'hFFFF1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    tbl[7]  = mk(6'h00, 6'h23, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110);
    tbl[8]  = mk(6'h00, 6'h22, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 3'b110);
    tbl[9]  = mk(6'h04, 6'h00, 32'h00000003, 32'h00000007, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110);
    tbl[10] = mk(6'h00, 6'h3F, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110);
    tbl[11] = mk(6'h00, 6'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111);
    tbl[12] = mk(6'h08, 6'h00, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
    tbl[13] = mk(6'h23, 6'h00, 32'h00000100, 32'h00000004, 32'h00000104, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_fields", {bus.rsp_result[27:0], bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf_trap, bus.rsp_illegal}, 32'd0);
    chk("reset_alu_op", 32'(bus.alu_op), 32'd0);
    chk("reset_alu_ab", bus.alu_A | bus.alu_B, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_cmd(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].e, i % 3, 1'b0);
    end

    // Backpressure: five cycles without rsp_ready while a new command waits
    run_cmd(6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001, tbl[0].e, 5, 1'b1);
    run_cmd(6'h3F, 6'h00, 32'h1, 32'h2, tbl[4].e, 5, 1'b1);

    // Reset during EXEC discards the command
    bus.cmd_valid = 1'b1; bus.cmd_opcode = 6'h00; bus.cmd_funct = 6'h22;
    bus.cmd_a = 32'd9; bus.cmd_b = 32'd4;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_alu_op = 3'b000;
    chk("rst_exec_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_exec_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_exec_alu_op", 32'(bus.alu_op), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Randomized commands against the reference model
    for (int i = 0; i < 200; i++) begin
      op = legal_ops[$urandom_range(0, 9)];
      fn = legal_fns[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      a = pick_operand();
      b = pick_operand();
      e = ref_model(op, fn, a, b);
      run_cmd(op, fn, a, b, e, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
